// File: rtl/alu_operand_loader.sv
// Operand capture stage: samples the switch bus on successive load presses into A then B,
// and offers the pair to the ALU stage with a valid/ready handshake.
module alu_operand_loader #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic             load,
  input  logic             clear,
  input  logic             ready_i,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             valid_o,
  output logic [1:0]       phase
);

  localparam logic [1:0] ST_A     = 2'd0;
  localparam logic [1:0] ST_B     = 2'd1;
  localparam logic [1:0] ST_VALID = 2'd2;

  logic             sync_s1_r;
  logic             sync_s2_r;
  logic             prev_r;
  logic             press_s;
  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] a_nxt_s;
  logic [WIDTH-1:0] b_nxt_s;
  logic             valid_s;

  // Load synchronizer and edge register; reset to 1 so a held button cannot fire a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_s1_r <= 1'b1;
      sync_s2_r <= 1'b1;
      prev_r    <= 1'b1;
    end else begin
      sync_s1_r <= load;
      sync_s2_r <= sync_s1_r;
      prev_r    <= sync_s2_r;
    end
  end

  assign press_s = sync_s2_r & ~prev_r;

  // State and operand registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_A;
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      a_r     <= a_nxt_s;
      b_r     <= b_nxt_s;
    end
  end

  // Next-state and operand capture; clear overrides press and ready_i.
  always_comb begin
    state_nxt_s = state_r;
    a_nxt_s     = a_r;
    b_nxt_s     = b_r;
    if (clear) begin
      state_nxt_s = ST_A;
      a_nxt_s     = {WIDTH{1'b0}};
      b_nxt_s     = {WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_A: begin
          if (press_s) begin
            a_nxt_s     = sw;
            state_nxt_s = ST_B;
          end else begin
            state_nxt_s = ST_A;
          end
        end
        ST_B: begin
          if (press_s) begin
            b_nxt_s     = sw;
            state_nxt_s = ST_VALID;
          end else begin
            state_nxt_s = ST_B;
          end
        end
        ST_VALID: begin
          // Presses here are dropped; operands hold across the transfer.
          if (ready_i) begin
            state_nxt_s = ST_A;
          end else begin
            state_nxt_s = ST_VALID;
          end
        end
        default: begin
          state_nxt_s = ST_A;
        end
      endcase
    end
  end

  // Moore output decode of the state register.
  always_comb begin
    valid_s = 1'b0;
    case (state_r)
      ST_VALID: valid_s = 1'b1;
      default:  valid_s = 1'b0;
    endcase
  end

  assign valid_o = valid_s;
  assign phase   = state_r;
  assign a       = a_r;
  assign b       = b_r;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Self-checking bench for alu_operand_loader: a behavioural model compared every cycle,
// plus directed vectors with hand-computed expectations.
module tb_alu_operand_loader;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] sw;
  logic         load;
  logic         clear;
  logic         ready_i;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         valid_o;
  logic [1:0]   phase;

  int n_checks = 0;
  int n_pass   = 0;

  alu_operand_loader #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .sw      (sw),
    .load    (load),
    .clear   (clear),
    .ready_i (ready_i),
    .a       (a),
    .b       (b),
    .valid_o (valid_o),
    .phase   (phase)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Behavioural model. load_hist[i] = load as sampled (i+1) edges ago; a press is a
  // 0->1 step of load seen two and three edges back.
  logic [2:0]   load_hist;
  int           m_stage;   // 0 = waiting for A, 1 = waiting for B, 2 = pair offered
  logic [W-1:0] m_a;
  logic [W-1:0] m_b;
  bit           chk_en = 1'b0;

  always @(posedge clk) begin
    logic pr;
    if (rst) begin
      load_hist = 3'b111;
      m_stage   = 0;
      m_a       = '0;
      m_b       = '0;
      chk_en    = 1'b1;
    end else begin
      pr = load_hist[1] && !load_hist[2];
      if (clear) begin
        m_stage = 0;
        m_a     = '0;
        m_b     = '0;
      end else if (m_stage == 0 && pr) begin
        m_a     = sw;
        m_stage = 1;
      end else if (m_stage == 1 && pr) begin
        m_b     = sw;
        m_stage = 2;
      end else if (m_stage == 2 && ready_i) begin
        m_stage = 0;
      end
      load_hist = {load_hist[1:0], load};
    end
  end

  // Compare process: outputs are stable at the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_a", a, m_a);
      check("model_b", b, m_b);
      check("model_valid", valid_o, (m_stage == 2) ? 1 : 0);
      check("model_phase", phase, m_stage);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [W-1:0] v);
    sw   = v;
    load = 1'b1;
    cyc(3);
    load = 1'b0;
    cyc(3);
  endtask

  initial begin
    rst = 1'b1; load = 1'b1; sw = 4'h0; clear = 1'b0; ready_i = 1'b0;
    cyc(3);
    check("rst_a", a, 4'h0);
    check("rst_b", b, 4'h0);
    check("rst_valid", valid_o, 1'b0);
    check("rst_phase", phase, 2'd0);
    rst = 1'b0;
    sw  = 4'h9;
    cyc(5);
    check("held_load_no_capture_phase", phase, 2'd0);
    check("held_load_no_capture_a", a, 4'h0);
    load = 1'b0;
    cyc(3);

    // First pulse: capture lands exactly on the third edge.
    sw = 4'hA; load = 1'b1;
    cyc(2);
    check("a_before_k2", a, 4'h0);
    cyc(1);
    check("a_at_k2", a, 4'hA);
    check("phase_after_a", phase, 2'd1);
    cyc(2);
    load = 1'b0;
    cyc(3);
    sw = 4'h6; load = 1'b1;
    cyc(3);
    check("b_captured", b, 4'h6);
    check("valid_after_b", valid_o, 1'b1);
    sw = 4'h0; load = 1'b0;
    cyc(10);
    check("valid_held", valid_o, 1'b1);
    check("phase_held", phase, 2'd2);
    ready_i = 1'b1;
    cyc(1);
    ready_i = 1'b0;
    check("xfer_valid", valid_o, 1'b0);
    check("xfer_phase", phase, 2'd0);
    check("xfer_a_kept", a, 4'hA);
    check("xfer_b_kept", b, 4'h6);
    cyc(2);

    // Long load: one capture only.
    sw = 4'h3; load = 1'b1;
    cyc(20);
    check("long_load_a", a, 4'h3);
    check("long_load_phase", phase, 2'd1);
    check("long_load_b_old", b, 4'h6);
    load = 1'b0;
    cyc(3);
    pulse(4'h9);
    check("valid_b9", b, 4'h9);

    // Press in ST_VALID is discarded.
    pulse(4'hF);
    check("ignored_a", a, 4'h3);
    check("ignored_b", b, 4'h9);
    check("ignored_phase", phase, 2'd2);
    ready_i = 1'b1;
    cyc(1);
    ready_i = 1'b0;
    cyc(5);
    check("no_queued_phase", phase, 2'd0);
    check("no_queued_a", a, 4'h3);

    // Clear coinciding with a press in ST_B.
    pulse(4'h5);
    check("stb_a5", a, 4'h5);
    sw = 4'h7; load = 1'b1;
    cyc(2);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    check("clr_a", a, 4'h0);
    check("clr_b", b, 4'h0);
    check("clr_phase", phase, 2'd0);
    load = 1'b0;
    cyc(3);
    check("clr_no_capture", a, 4'h0);

    // Clear beats ready_i in ST_VALID.
    pulse(4'h2);
    pulse(4'h4);
    check("pre_clr_valid", valid_o, 1'b1);
    clear = 1'b1; ready_i = 1'b1;
    cyc(1);
    clear = 1'b0; ready_i = 1'b0;
    check("clr_ready_a", a, 4'h0);
    check("clr_ready_b", b, 4'h0);
    check("clr_ready_phase", phase, 2'd0);
    cyc(2);

    // ready_i tied high: one-cycle valid.
    ready_i = 1'b1;
    pulse(4'hC);
    check("tied_a", a, 4'hC);
    sw = 4'hA; load = 1'b1;
    cyc(3);
    check("tied_valid_on", valid_o, 1'b1);
    cyc(1);
    check("tied_valid_off", valid_o, 1'b0);
    check("tied_phase", phase, 2'd0);
    check("and_result", a & b, 4'h8);
    load = 1'b0;
    cyc(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_operand_loader.md
# alu_operand_loader

Operand capture stage that sits directly upstream of the ALU bitwise/arithmetic units. It samples a shared switch bus on successive presses of a load button, registers operand A then operand B, and presents both with a valid/ready handshake to the ALU stage. The operands are held stable after acceptance, so downstream combinational units and displays keep showing the last operand pair.

## Interface
Parameters:
- WIDTH, 4, operand width in bits; applies to sw, a and b.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- sw  input  WIDTH  operand value from board switches; sampled directly, no synchronizer.
- load  input  1  load push-button; asynchronous to clk, already debounced.
- clear  input  1  synchronous abort; zeroes the operands and restarts the sequence.
- ready_i  input  1  ALU stage accepts the operand pair this cycle.
- a  output  WIDTH  registered operand A.
- b  output  WIDTH  registered operand B.
- valid_o  output  1  the operand pair is complete and offered to the ALU stage.
- phase  output  2  current FSM state encoding, for LEDs: 0 = ST_A, 1 = ST_B, 2 = ST_VALID.

## Operation
- load passes through a 2-flop synchronizer (s1, s2) and then an edge register (prev). press = s2 & ~prev.
- FSM states:
  - ST_A: on press, a <= sw and the FSM moves to ST_B.
  - ST_B: on press, b <= sw and the FSM moves to ST_VALID.
  - ST_VALID: valid_o = 1. On ready_i, the FSM moves to ST_A and a, b keep their values. A press in this state is ignored and discarded, not queued.
- Encoding 3 is unreachable. If the FSM ever enters it, the next edge returns it to ST_A.
- clear, in any state: a <= 0, b <= 0, FSM goes to ST_A. clear has priority over press and over ready_i in the same cycle.
- rst: same effect as clear. In addition, s1, s2 and prev are set to 1, so a load held high through reset does not produce a press. A press requires load to go low and then high again.
- Handshake: valid_o is Moore, equal to (state == ST_VALID). A transfer occurs on any edge where valid_o & ready_i. a and b must not change while valid_o is 1.
- ready_i is ignored outside ST_VALID.
- sw is sampled only on the capture edge. sw changes at any other time have no effect.

## Timing
- Reset values: a = 0, b = 0, valid_o = 0, phase = 0.
- load latency: load first sampled high at edge k gives s1 = 1 at k and s2 = 1 at k+1. press is high during the cycle after k+1. The capture (a or b update, and the state change) happens at edge k+2.
- A press lasts exactly one clk cycle, however long load is held.
- B captured at edge n gives valid_o = 1 from edge n. With ready_i already high, the transfer occurs at edge n+1, and valid_o = 0 and phase = 0 from edge n+1.
- Minimum time between consecutive captures: 2 cycles, because load must drop and rise again.
- Back-to-back sequences: after a transfer, the next press captures a new A. The old b remains visible until it is overwritten.

## Test plan
- Reset with load held high, then release rst: a = 0, b = 0, valid_o = 0, phase = 0, and no capture while load stays high.
- sw = 4'hA with a load pulse, then sw = 4'h6 with a second pulse, ready_i = 0: a = 4'hA at edge k+2 of the first pulse, b = 4'h6 after the second, then valid_o = 1 and phase = 2 held for 10 cycles. Assert ready_i for one cycle: valid_o = 0, phase = 0, a = 4'hA and b = 4'h6 retained.
- load held high for 20 cycles in ST_A with sw = 4'h3: exactly one capture (a = 4'h3), phase = 1.
- In ST_VALID, pulse load with sw = 4'hF: a and b unchanged, still ST_VALID. Then assert ready_i: the transfer completes and no capture is queued.
- In ST_B with a = 4'h5, assert clear together with a press: a = 0, b = 0, phase = 0, and no capture of sw.
- Full sequence with ready_i tied to 1: valid_o is high for exactly 1 cycle. The bitwise AND of a and b equals the expected value, e.g. 4'hC & 4'hA = 4'h8.
